// File: rtl/psg_pkg.sv
// Shared constants and types for the SN76489-style register-write receiver.
// Latch-byte field layout, channel/type codes and the stored latch record.
package psg_pkg;

    localparam int LATCH_BIT = 7;

    localparam logic [1:0] CH_TONE0 = 2'd0;
    localparam logic [1:0] CH_TONE1 = 2'd1;
    localparam logic [1:0] CH_TONE2 = 2'd2;
    localparam logic [1:0] CH_NOISE = 2'd3;

    localparam logic TYPE_TONE = 1'b0;
    localparam logic TYPE_VOL  = 1'b1;

    localparam logic [3:0] ATT_SILENT = 4'hF;

    typedef struct packed {
        logic [1:0] channel;
        logic       typ;
    } latch_t;

    // Latch byte layout: d[6:5] channel, d[4] type.
    function automatic latch_t decode_latch(input logic [7:0] b);
        latch_t l;
        l.channel = b[6:5];
        l.typ     = b[4];
        return l;
    endfunction

endpackage

// File: rtl/psg_reg_rx_if.sv
// Write-port bundle between the sound CPU write logic and the PSG receiver.
// The master drives the strobe, chip select, write and data; the PSG returns ready.
interface psg_reg_rx_if;
    logic       cen;
    logic       ce_n;
    logic       we_n;
    logic [7:0] d;
    logic       ready;

    modport master (output cen, output ce_n, output we_n, output d, input ready);
    modport slave  (input cen, input ce_n, input we_n, input d, output ready);
endinterface

// File: rtl/psg_busy_timer.sv
// Busy timer: ready drops on an accepted write and returns after BUSY_TICKS
// cen ticks, counted from the accept edge.
module psg_busy_timer #(
    parameter int BUSY_TICKS = 32
) (
    input  logic clk12m,
    input  logic reset,
    input  logic cen,
    input  logic accept,
    output logic ready
);

    localparam logic [7:0] LOAD = 8'(BUSY_TICKS - 1);

    logic [7:0] count_reg;

    always_ff @(posedge clk12m or posedge reset) begin
        if (reset) begin
            ready     <= 1'b1;
            count_reg <= 8'd0;
        end else if (accept) begin
            ready     <= 1'b0;
            count_reg <= LOAD;
        end else if (cen && !ready) begin
            // A zero count at a cen edge ends the busy period on that edge.
            if (count_reg == 8'd0) begin
                ready <= 1'b1;
            end else begin
                count_reg <= count_reg - 8'd1;
            end
        end
    end

endmodule

// File: rtl/psg_reg_rx.sv
// PSG register-write receiver: accepts bytes on the write port, decodes latch and
// data bytes into tone, attenuation and noise registers, and paces writes via ready.
module psg_reg_rx
    import psg_pkg::*;
#(
    parameter int BUSY_TICKS = 32
) (
    input  logic          clk12m,
    input  logic          reset,
    psg_reg_rx_if.slave   bus,
    output logic [9:0]    tone0,
    output logic [9:0]    tone1,
    output logic [9:0]    tone2,
    output logic [3:0]    att0,
    output logic [3:0]    att1,
    output logic [3:0]    att2,
    output logic [3:0]    att3,
    output logic [2:0]    noise_ctl,
    output logic          noise_rst
);

    logic       ready_int;
    logic       accept;
    logic       is_latch;
    latch_t     target;
    latch_t     latch_reg;
    logic [2:0] tone_hit;
    logic [3:0] att_hit;
    logic       noise_hit;

    logic [9:0] tone_reg [3];
    logic [3:0] att_reg  [4];
    logic [2:0] noise_ctl_reg;
    logic       noise_rst_reg;

    assign accept   = bus.cen && !bus.ce_n && !bus.we_n && ready_int;
    assign is_latch = bus.d[LATCH_BIT];
    // Data bytes reuse the stored latch; latch bytes address themselves.
    assign target   = is_latch ? decode_latch(bus.d) : latch_reg;

    always_comb begin
        tone_hit  = 3'b000;
        noise_hit = 1'b0;
        if (target.typ == TYPE_TONE) begin
            case (target.channel)
                CH_TONE0: tone_hit  = 3'b001;
                CH_TONE1: tone_hit  = 3'b010;
                CH_TONE2: tone_hit  = 3'b100;
                CH_NOISE: noise_hit = 1'b1;
                default:  tone_hit  = 3'b000;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_att_hit
            assign att_hit[gi] = (target.typ == TYPE_VOL) && (target.channel == 2'(gi));
        end
    endgenerate

    psg_busy_timer #(
        .BUSY_TICKS (BUSY_TICKS)
    ) u_busy_timer (
        .clk12m (clk12m),
        .reset  (reset),
        .cen    (bus.cen),
        .accept (accept),
        .ready  (ready_int)
    );

    assign bus.ready = ready_int;

    always_ff @(posedge clk12m or posedge reset) begin
        if (reset) begin
            latch_reg.channel <= CH_TONE0;
            latch_reg.typ     <= TYPE_TONE;
            for (int i = 0; i < 3; i++) tone_reg[i] <= 10'd0;
            for (int i = 0; i < 4; i++) att_reg[i] <= ATT_SILENT;
            noise_ctl_reg <= 3'd0;
            noise_rst_reg <= 1'b0;
        end else begin
            noise_rst_reg <= 1'b0;
            if (accept) begin
                if (is_latch) begin
                    latch_reg <= target;
                end
                // Latch bytes carry the low tone nibble, data bytes the upper six bits.
                for (int i = 0; i < 3; i++) begin
                    if (tone_hit[i]) begin
                        if (is_latch) begin
                            tone_reg[i][3:0] <= bus.d[3:0];
                        end else begin
                            tone_reg[i][9:4] <= bus.d[5:0];
                        end
                    end
                end
                for (int i = 0; i < 4; i++) begin
                    if (att_hit[i]) begin
                        att_reg[i] <= bus.d[3:0];
                    end
                end
                if (noise_hit) begin
                    noise_ctl_reg <= bus.d[2:0];
                    noise_rst_reg <= 1'b1;
                end
            end
        end
    end

    assign tone0     = tone_reg[0];
    assign tone1     = tone_reg[1];
    assign tone2     = tone_reg[2];
    assign att0      = att_reg[0];
    assign att1      = att_reg[1];
    assign att2      = att_reg[2];
    assign att3      = att_reg[3];
    assign noise_ctl = noise_ctl_reg;
    assign noise_rst = noise_rst_reg;

endmodule

// File: tb/tb_psg_reg_rx.sv
// Directed bench for psg_reg_rx: cen every 4 clk12m, BUSY_TICKS=32.
// Each scenario task drives writes and checks registers, ready and noise_rst inline.
`timescale 1ns/1ps
module tb_psg_reg_rx;

    logic       clk12m = 1'b0;
    logic       reset  = 1'b1;
    logic [9:0] tone0, tone1, tone2;
    logic [3:0] att0, att1, att2, att3;
    logic [2:0] noise_ctl;
    logic       noise_rst;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit cen_en = 1'b1;

    psg_reg_rx_if ifc ();

    psg_reg_rx #(
        .BUSY_TICKS (32)
    ) dut (
        .clk12m    (clk12m),
        .reset     (reset),
        .bus       (ifc),
        .tone0     (tone0),
        .tone1     (tone1),
        .tone2     (tone2),
        .att0      (att0),
        .att1      (att1),
        .att2      (att2),
        .att3      (att3),
        .noise_ctl (noise_ctl),
        .noise_rst (noise_rst)
    );

    always #5 clk12m = ~clk12m;

    // cen strobe: one clk12m in four, updated on the falling edge.
    initial begin
        ifc.cen = 1'b0;
        forever begin
            @(negedge clk12m);
            cyc = cyc + 1;
            ifc.cen = cen_en && (cyc % 4 == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int n = 0;
        while (!ifc.ready && n < 2000) begin
            @(posedge clk12m); #1;
            n++;
        end
        checks++;
        if (ifc.ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: ready=%b required 1 within 2000 cycles", ifc.ready);
        end
    endtask

    // Holds the strobe until ready falls (the accept edge), then releases it.
    task automatic write_byte(input logic [7:0] b);
        int n = 0;
        wait_ready();
        @(negedge clk12m);
        ifc.ce_n = 1'b0; ifc.we_n = 1'b0; ifc.d = b;
        do begin
            @(posedge clk12m); #1;
            n++;
        end while (ifc.ready && n < 100);
        checks++;
        if (ifc.ready !== 1'b0) begin
            errors++;
            $display("FAIL write_accept d=%h: ready=%b required 0", b, ifc.ready);
        end
        @(negedge clk12m);
        ifc.ce_n = 1'b1; ifc.we_n = 1'b1;
        $display("write d=%h accepted after %0d cycles", b, n);
    endtask

    task automatic measure_busy(input int expected, input string tag);
        int n = 0;
        while (!ifc.ready && n < 1000) begin
            @(posedge clk12m); #1;
            n++;
        end
        checks++;
        if (n !== expected) begin
            errors++;
            $display("FAIL busy_%s: ready low %0d clk12m required %0d", tag, n, expected);
        end
    endtask

    task automatic wait_cen(input int n);
        repeat (n) begin
            do @(posedge clk12m); while (!ifc.cen);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({ifc.ready, tone0, tone1, tone2} !== {1'b1, 30'd0}) begin
            errors++;
            $display("FAIL reset_tones: ready=%b tones=%h/%h/%h required 1 and 0/0/0",
                     ifc.ready, tone0, tone1, tone2);
        end
        checks++;
        if ({att0, att1, att2, att3, noise_ctl, noise_rst} !== {16'hFFFF, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_att_noise: att=%h%h%h%h ctl=%0d rst=%b required FFFF 0 0",
                     att0, att1, att2, att3, noise_ctl, noise_rst);
        end
    endtask

    task automatic test_tone();
        write_byte(8'h8E);
        checks++;
        if (tone0 !== 10'h00E) begin
            errors++;
            $display("FAIL tone_latch: tone0=%h required 00E", tone0);
        end
        measure_busy(128, "tone_latch");
        write_byte(8'h0F);
        checks++;
        if (tone0 !== 10'h0FE) begin
            errors++;
            $display("FAIL tone_data: tone0=%h required 0FE", tone0);
        end
        measure_busy(128, "tone_data");
    endtask

    task automatic test_volume();
        write_byte(8'hBF);
        checks++;
        if (att1 !== 4'hF) begin
            errors++;
            $display("FAIL vol_latch: att1=%h required F", att1);
        end
        write_byte(8'h03);
        checks++;
        if ({att1, tone1, att0} !== {4'h3, 10'h000, 4'hF}) begin
            errors++;
            $display("FAIL vol_data: att1=%h tone1=%h att0=%h required 3 000 F", att1, tone1, att0);
        end
    endtask

    task automatic test_noise();
        write_byte(8'hE5);
        checks++;
        if ({noise_ctl, noise_rst} !== {3'd5, 1'b1}) begin
            errors++;
            $display("FAIL noise_latch: ctl=%0d rst=%b required 5 1", noise_ctl, noise_rst);
        end
        @(posedge clk12m); #1;
        checks++;
        if (noise_rst !== 1'b0) begin
            errors++;
            $display("FAIL noise_rst_width1: rst=%b required 0", noise_rst);
        end
        write_byte(8'h02);
        checks++;
        if ({noise_ctl, noise_rst} !== {3'd2, 1'b1}) begin
            errors++;
            $display("FAIL noise_data: ctl=%0d rst=%b required 2 1", noise_ctl, noise_rst);
        end
        @(posedge clk12m); #1;
        checks++;
        if (noise_rst !== 1'b0) begin
            errors++;
            $display("FAIL noise_rst_width2: rst=%b required 0", noise_rst);
        end
    endtask

    task automatic test_ignored();
        wait_ready();
        // Strobe with cen held low.
        @(posedge clk12m); cen_en = 1'b0;
        @(negedge clk12m);
        ifc.ce_n = 1'b0; ifc.we_n = 1'b0; ifc.d = 8'h80;
        repeat (8) @(posedge clk12m);
        #1;
        checks++;
        if ({ifc.ready, tone0} !== {1'b1, 10'h0FE}) begin
            errors++;
            $display("FAIL ign_cen0: ready=%b tone0=%h required 1 0FE", ifc.ready, tone0);
        end
        @(negedge clk12m);
        ifc.ce_n = 1'b1; ifc.we_n = 1'b1;
        @(posedge clk12m); cen_en = 1'b1;
        $display("ignored strobe with cen=0 d=80");

        // Chip select without write strobe.
        @(negedge clk12m);
        ifc.ce_n = 1'b0; ifc.we_n = 1'b1; ifc.d = 8'h9A;
        repeat (8) @(posedge clk12m);
        #1;
        checks++;
        if ({ifc.ready, att0} !== {1'b1, 4'hF}) begin
            errors++;
            $display("FAIL ign_we1: ready=%b att0=%h required 1 F", ifc.ready, att0);
        end
        @(negedge clk12m);
        ifc.ce_n = 1'b1;
        $display("ignored ce_n=0 we_n=1 d=9A");

        // Strobe landing on tick 10 of a busy period.
        write_byte(8'h8E);
        wait_cen(9);
        @(negedge clk12m);
        ifc.ce_n = 1'b0; ifc.we_n = 1'b0; ifc.d = 8'hD0;
        wait_cen(1);
        #1;
        @(negedge clk12m);
        ifc.ce_n = 1'b1; ifc.we_n = 1'b1;
        checks++;
        if ({ifc.ready, att2, tone0} !== {1'b0, 4'hF, 10'h0FE}) begin
            errors++;
            $display("FAIL ign_busy: ready=%b att2=%h tone0=%h required 0 F 0FE",
                     ifc.ready, att2, tone0);
        end
        $display("ignored busy strobe d=D0");
        wait_ready();
    endtask

    task automatic test_back_to_back();
        int falls = 0;
        int ticks = 0;
        bit prev;
        bit was_cen;
        wait_ready();
        prev = ifc.ready;
        @(negedge clk12m);
        ifc.ce_n = 1'b0; ifc.we_n = 1'b0; ifc.d = 8'h97;
        while (ticks < 41) begin
            @(posedge clk12m);
            was_cen = ifc.cen;
            #1;
            if (prev && !ifc.ready) falls++;
            prev = ifc.ready;
            if (was_cen) ticks++;
        end
        @(negedge clk12m);
        ifc.ce_n = 1'b1; ifc.we_n = 1'b1;
        checks++;
        if (falls !== 2) begin
            errors++;
            $display("FAIL b2b_count: %0d writes accepted required 2", falls);
        end
        checks++;
        if (att0 !== 4'h7) begin
            errors++;
            $display("FAIL b2b_att0: att0=%h required 7", att0);
        end
        $display("held strobe d=97 over 41 cen ticks: %0d accepts", falls);
        wait_ready();
    endtask

    task automatic test_reset_mid_busy();
        write_byte(8'hC4);
        checks++;
        if (tone2 !== 10'h004) begin
            errors++;
            $display("FAIL rst_pre_tone2: tone2=%h required 004", tone2);
        end
        repeat (20) @(posedge clk12m);
        @(negedge clk12m);
        reset = 1'b1;
        #1;
        checks++;
        if ({ifc.ready, tone0, tone2, att0, att1, noise_ctl, noise_rst}
                !== {1'b1, 10'h000, 10'h000, 4'hF, 4'hF, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_busy: ready=%b tone0=%h tone2=%h att0=%h att1=%h ctl=%0d rst=%b required 1 000 000 F F 0 0",
                     ifc.ready, tone0, tone2, att0, att1, noise_ctl, noise_rst);
        end
        @(negedge clk12m);
        reset = 1'b0;
        $display("reset asserted mid-busy and released");
        write_byte(8'h0F);
        checks++;
        if (tone0 !== 10'h0F0) begin
            errors++;
            $display("FAIL rst_latch_default: tone0=%h required 0F0", tone0);
        end
    endtask

    initial begin
        ifc.ce_n = 1'b1;
        ifc.we_n = 1'b1;
        ifc.d    = 8'h00;
        repeat (3) @(negedge clk12m);
        reset = 1'b0;
        @(posedge clk12m); #1;
        test_reset();
        test_tone();
        test_volume();
        test_noise();
        test_ignored();
        test_back_to_back();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
